pipe_mux_n: RTL and testbench



---
 rtl/pipe_mux_n_if.sv | 26 ++
 rtl/pipe_mux_n.sv | 133 +++++++++++++
 tb/tb_pipe_mux_n.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_mux_n_if.sv
// Handshake bundle for pipe_mux_n: upstream select/data request, downstream result and sticky select error.
interface pipe_mux_n_if #(
  parameter int WIDTH = 64,
  parameter int N     = 16
) ();
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [SW-1:0]      in_sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               sel_err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
endinterface

// File: rtl/pipe_mux_n.sv
// Two-stage pipelined N:1 word mux with valid/ready stalls; stage 1 picks inside groups, stage 2 across groups.
// Optional sticky out-of-range select flag under `SEL_RANGE_CHECK_EN.
module pipe_mux_n_grp #(
  parameter int WIDTH = 64,
  parameter int GROUP = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en_i,
  input  logic [$clog2(GROUP)-1:0]        lsel_i,
  input  logic [GROUP-1:0][WIDTH-1:0]     words_i,
  output logic [WIDTH-1:0]                win_o
);
  logic [WIDTH-1:0] win_d, win_q;

  assign win_d = en_i ? words_i[lsel_i] : win_q;
  assign win_o = win_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) win_q <= '0;
    else          win_q <= win_d;
endmodule

module pipe_mux_n #(
  parameter int WIDTH = 64,
  parameter int N     = 16,
  parameter int GROUP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  pipe_mux_n_if.slave bus
);
  localparam int STAGES = 2;
  localparam int SW     = (N > 1) ? $clog2(N) : 1;
  localparam int LG     = $clog2(GROUP);
  localparam int NG     = (N + GROUP - 1) / GROUP;
  localparam int HSW    = (SW > LG) ? SW - LG : 1;
  localparam int NH     = 1 << HSW;

  typedef struct packed {
    logic [HSW-1:0] hs;
`ifdef SEL_RANGE_CHECK_EN
    logic           oor;
`endif
  } s1_meta_t;

  logic [STAGES:1]                vld_pipe_d, vld_pipe_q;
  logic                           s2_ld, s1_ld, acc, s2_take;
  logic [SW-1:0]                  sel;
  logic [NG*GROUP-1:0][WIDTH-1:0] pad;
  logic [NH-1:0][WIDTH-1:0]       win;
  s1_meta_t                       meta_d, meta_q;
  logic [WIDTH-1:0]               data_d, data_q;

  assign s2_ld        = !vld_pipe_q[2] || bus.out_ready;
  assign s1_ld        = !vld_pipe_q[1] || s2_ld;
  assign acc          = bus.in_valid && s1_ld;
  assign s2_take      = s2_ld && vld_pipe_q[1];
  assign sel          = bus.in_sel;
  assign bus.in_ready = s1_ld;

  // Indices past N are padded with zero so any out-of-range select yields zero data.
  for (genvar i = 0; i < NG*GROUP; i++) begin : g_pad
    if (i < N) begin : g_w
      assign pad[i] = bus.in_data[i*WIDTH +: WIDTH];
    end else begin : g_z
      assign pad[i] = '0;
    end
  end

  for (genvar g = 0; g < NH; g++) begin : g_grp
    if (g < NG) begin : g_lane
      pipe_mux_n_grp #(.WIDTH(WIDTH), .GROUP(GROUP)) u_grp (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (acc),
        .lsel_i  (sel[LG-1:0]),
        .words_i (pad[g*GROUP +: GROUP]),
        .win_o   (win[g])
      );
    end else begin : g_none
      assign win[g] = '0;
    end
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    meta_d     = meta_q;
    data_d     = data_q;
    if (s1_ld) vld_pipe_d[1] = acc;
    if (s2_ld) vld_pipe_d[2] = vld_pipe_q[1];
    if (acc) begin
      meta_d.hs  = HSW'(sel >> LG);
`ifdef SEL_RANGE_CHECK_EN
      meta_d.oor = (32'(sel) >= 32'(N));
`endif
    end
    if (s2_take) begin
      data_d = win[meta_q.hs];
`ifdef SEL_RANGE_CHECK_EN
      if (meta_q.oor) data_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_pipe_q <= '0;
      meta_q     <= '0;
      data_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      meta_q     <= meta_d;
      data_q     <= data_d;
    end

`ifdef SEL_RANGE_CHECK_EN
  logic err_d, err_q;

  assign err_d = err_q || (s2_take && meta_q.oor);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;

  assign bus.sel_err = err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_data  = data_q;
endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed checks of pipe_mux_n (reset, latency, streaming, backpressure, range, mid-op reset) plus a parameter sweep.
module tb_pipe_mux_n;
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic sweep_go = 1'b0;
  bit   sw_done [3] = '{default: 1'b0};

`ifdef SEL_RANGE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  pipe_mux_n_if #(.WIDTH(64), .N(16)) a_if ();
  pipe_mux_n #(.WIDTH(64), .N(16), .GROUP(4)) u_a (.clk(clk), .reset_n(reset_n), .bus(a_if.slave));
  pipe_mux_n_if #(.WIDTH(64), .N(12)) b_if ();
  pipe_mux_n #(.WIDTH(64), .N(12), .GROUP(4)) u_b (.clk(clk), .reset_n(reset_n), .bus(b_if.slave));

  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int SN  = (k == 0) ? 2 : (k == 1) ? 5 : 32;
    localparam int SG  = (k == 0) ? 2 : (k == 1) ? 4 : 8;
    localparam int SSW = $clog2(SN);
    pipe_mux_n_if #(.WIDTH(16), .N(SN)) s_if ();
    pipe_mux_n #(.WIDTH(16), .N(SN), .GROUP(SG)) u_s (.clk(clk), .reset_n(reset_n), .bus(s_if.slave));
    logic [15:0] q[$];

    initial begin
      int acc_n;
      int sidx;
      bit saw_oor;
      logic [15:0] w;
      s_if.in_valid  = 1'b0;
      s_if.in_sel    = '0;
      s_if.in_data   = '0;
      s_if.out_ready = 1'b1;
      acc_n   = 0;
      saw_oor = 1'b0;
      wait (sweep_go);
      for (int c = 0; c < 40000 && (acc_n < 10000 || q.size() != 0); c++) begin
        @(negedge clk);
        s_if.out_ready = ($urandom_range(9) < 7) || (acc_n >= 10000);
        if (s_if.out_valid && s_if.out_ready) begin
          if (q.size() == 0) chk($sformatf("sw%0d_extra", k), 64'(q.size()), 64'd1);
          else               chk($sformatf("sw%0d_data", k), 64'(s_if.out_data), 64'(q.pop_front()));
        end
        s_if.in_valid = (acc_n < 10000) && ($urandom_range(9) < 8);
        s_if.in_sel   = SSW'($urandom_range(32'((1 << SSW) - 1)));
        for (int i = 0; i < SN; i++) s_if.in_data[i*16 +: 16] = 16'($urandom);
        #1;
        if (s_if.in_valid && s_if.in_ready) begin
          sidx = int'(s_if.in_sel);
          w = (sidx < SN) ? s_if.in_data[sidx*16 +: 16] : 16'h0;
          if (sidx >= SN) saw_oor = 1'b1;
          q.push_back(w);
          acc_n++;
        end
      end
      chk($sformatf("sw%0d_count", k), 64'(acc_n), 64'd10000);
      chk($sformatf("sw%0d_drain", k), 64'(q.size()), 64'd0);
      chk($sformatf("sw%0d_err", k), 64'(s_if.sel_err), 64'(ERR_EXP & saw_oor));
      sw_done[k] = 1'b1;
    end
  end

  initial begin
    int idx, rx;
    a_if.in_valid  = 1'b0;
    a_if.in_sel    = '0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) a_if.in_data[i*64 +: 64] = 64'h1000 + 64'(i);
    b_if.in_valid  = 1'b0;
    b_if.in_sel    = '0;
    b_if.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) b_if.in_data[i*64 +: 64] = 64'h2000 + 64'(i);

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_vld",  64'(a_if.out_valid), 64'd0);
    chk("rst_a_data", a_if.out_data,       64'd0);
    chk("rst_a_err",  64'(a_if.sel_err),   64'd0);
    chk("rst_b_vld",  64'(b_if.out_valid), 64'd0);
    chk("rst_b_err",  64'(b_if.sel_err),   64'd0);
    reset_n = 1'b1;

    @(negedge clk);
    a_if.in_sel = 4'd13; a_if.in_valid = 1'b1;
    #1 chk("t1_rdy", 64'(a_if.in_ready), 64'd1);
    @(negedge clk); a_if.in_valid = 1'b0;
    chk("t1_lat1", 64'(a_if.out_valid), 64'd0);
    @(negedge clk);
    chk("t1_vld",  64'(a_if.out_valid), 64'd1);
    chk("t1_data", a_if.out_data, 64'h100D);
    @(negedge clk);
    chk("t1_pulse", 64'(a_if.out_valid), 64'd0);

    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("str_vld",  64'(a_if.out_valid), 64'd1);
        chk("str_data", a_if.out_data, 64'h1000 + 64'(c - 2));
      end
      if (c < 16) begin
        a_if.in_sel = 4'(c); a_if.in_valid = 1'b1;
        #1 chk("str_rdy", 64'(a_if.in_ready), 64'd1);
      end else a_if.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("str_end", 64'(a_if.out_valid), 64'd0);

    idx = 0; rx = 0;
    a_if.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 6) a_if.out_ready = 1'b1;
      if (c >= 2 && c < 6) begin
        chk("bp_hold_vld",  64'(a_if.out_valid), 64'd1);
        chk("bp_hold_data", a_if.out_data, 64'h1000);
      end
      if (a_if.out_valid && a_if.out_ready) begin
        chk("bp_order", a_if.out_data, 64'h1000 + 64'(rx));
        rx++;
      end
      if (idx < 4) begin a_if.in_sel = 4'(idx); a_if.in_valid = 1'b1; end
      else a_if.in_valid = 1'b0;
      #1;
      if (c >= 2 && c < 6) chk("bp_rdy_low", 64'(a_if.in_ready), 64'd0);
      if (a_if.in_valid && a_if.in_ready) idx++;
    end
    chk("bp_rx",   64'(rx),  64'd4);
    chk("bp_sent", 64'(idx), 64'd4);

    a_if.out_ready = 1'b0;
    @(negedge clk); a_if.in_sel = 4'd3; a_if.in_valid = 1'b1;
    @(negedge clk); a_if.in_sel = 4'd4;
    @(negedge clk); a_if.in_valid = 1'b0;
    chk("rm_pre_vld",  64'(a_if.out_valid), 64'd1);
    chk("rm_pre_full", 64'(a_if.in_ready),  64'd0);
    reset_n = 1'b0;
    #2;
    chk("rm_vld",  64'(a_if.out_valid), 64'd0);
    chk("rm_data", a_if.out_data, 64'd0);
    #1 reset_n = 1'b1;
    a_if.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rm_stale", 64'(a_if.out_valid), 64'd0);
    end
    a_if.in_sel = 4'd7; a_if.in_valid = 1'b1;
    #1 chk("rm_rdy", 64'(a_if.in_ready), 64'd1);
    @(negedge clk); a_if.in_valid = 1'b0;
    chk("rm_lat1", 64'(a_if.out_valid), 64'd0);
    @(negedge clk);
    chk("rm_vld2", 64'(a_if.out_valid), 64'd1);
    chk("rm_data2", a_if.out_data, 64'h1007);

    @(negedge clk); b_if.in_sel = 4'd11; b_if.in_valid = 1'b1;
    @(negedge clk); b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("inr_vld",  64'(b_if.out_valid), 64'd1);
    chk("inr_data", b_if.out_data, 64'h200B);
    chk("inr_err",  64'(b_if.sel_err), 64'd0);
    b_if.in_sel = 4'd14; b_if.in_valid = 1'b1;
    @(negedge clk); b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("oor_vld",  64'(b_if.out_valid), 64'd1);
    chk("oor_data", b_if.out_data, 64'd0);
    chk("oor_err",  64'(b_if.sel_err), 64'(ERR_EXP));
    repeat (10) @(negedge clk);
    chk("oor_sticky", 64'(b_if.sel_err), 64'(ERR_EXP));
    chk("oor_idle",   64'(b_if.out_valid), 64'd0);

    sweep_go = 1'b1;
    for (int c = 0; c < 60000 && !(sw_done[0] && sw_done[1] && sw_done[2]); c++) @(posedge clk);
    chk("sweep_done", 64'({sw_done[2], sw_done[1], sw_done[0]}), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
